// File: rtl/taiga_types.sv
// Shared RCA/LSU types: the per-channel request record, arbiter states and default widths.
package taiga_types;

    localparam int RCA_LSU_NUM_CHANNELS = 4;
    localparam int RCA_LSU_XLEN         = 32;
    localparam int RCA_LSU_ID_W         = 3;
    localparam int RCA_LSU_CH_W         = $clog2(RCA_LSU_NUM_CHANNELS);

    typedef struct packed {
        logic [RCA_LSU_XLEN-1:0] rs1;
        logic [RCA_LSU_XLEN-1:0] rs2;
        logic [2:0]              fn3;
        logic                    load;
        logic                    store;
        logic [RCA_LSU_ID_W-1:0] id;
        logic                    lock;
    } rca_lsu_req_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } rca_lsu_arb_state_t;

endpackage

// File: rtl/rca_lsu_tag_fifo.sv
// In-order FIFO of issuing-channel indices, one entry per outstanding load.
module rca_lsu_tag_fifo
    import taiga_types::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = RCA_LSU_CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // An empty pop is ignored so an underflowing completion leaves the state untouched.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rca_lsu_arbiter.sv
// Round-robin arbiter sharing the RCA-to-LSU port, with grant lock and in-order load routing.
// Define RCA_LSU_ARB_STATS_EN to add per-channel accepted-request counters (ch_grant_count).
module rca_lsu_arbiter
    import taiga_types::*;
#(
    parameter int NUM_CHANNELS       = RCA_LSU_NUM_CHANNELS,
    parameter int MAX_INFLIGHT_LOADS = 4,
    parameter int XLEN               = RCA_LSU_XLEN,
    parameter int ID_W               = RCA_LSU_ID_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CHANNELS-1:0]      ch_req_valid,
    output logic [NUM_CHANNELS-1:0]      ch_req_ready,
    input  logic [NUM_CHANNELS*XLEN-1:0] ch_rs1,
    input  logic [NUM_CHANNELS*XLEN-1:0] ch_rs2,
    input  logic [NUM_CHANNELS*3-1:0]    ch_fn3,
    input  logic [NUM_CHANNELS-1:0]      ch_load,
    input  logic [NUM_CHANNELS-1:0]      ch_store,
    input  logic [NUM_CHANNELS*ID_W-1:0] ch_id,
    input  logic [NUM_CHANNELS-1:0]      ch_lock,
    output logic [NUM_CHANNELS-1:0]      ch_load_complete,
    output logic [XLEN-1:0]              ch_load_data,
    output logic                         ls_new_request,
    output logic [XLEN-1:0]              ls_rs1,
    output logic [XLEN-1:0]              ls_rs2,
    output logic [2:0]                   ls_fn3,
    output logic                         ls_load,
    output logic                         ls_store,
    output logic [ID_W-1:0]              ls_id,
    output logic                         ls_lock,
    input  logic                         lsu_ready,
    input  logic                         lsu_load_complete,
    input  logic [XLEN-1:0]              lsu_load_data,
`ifdef RCA_LSU_ARB_STATS_EN
    output logic [NUM_CHANNELS*32-1:0]   ch_grant_count,
`endif
    output logic                         tag_underflow
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    rca_lsu_arb_state_t state_q, state_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]    locked_ch_q, locked_ch_d;
    logic               tag_underflow_q, tag_underflow_d;

    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] candidate;
    logic [CH_W:0]           scan_idx;
    logic                    grant_found;
    logic [CH_W-1:0]         grant_idx;
    rca_lsu_req_t            sel_req;

    logic            fifo_push, fifo_full, fifo_empty;
    logic [CH_W-1:0] fifo_head;

    // A load is held off while the tag FIFO is full, even if a completion pops it this cycle.
    always_comb begin
        eligible    = '0;
        candidate   = '0;
        scan_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            eligible[i] = ch_req_valid[i] & ~(ch_load[i] & ch_store[i]) & ~(ch_load[i] & fifo_full);
        end
        if (state_q == LOCKED) begin
            candidate[locked_ch_q] = eligible[locked_ch_q];
        end else begin
            candidate = eligible;
        end
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
            if (scan_idx >= (CH_W+1)'(NUM_CHANNELS)) begin
                scan_idx = scan_idx - (CH_W+1)'(NUM_CHANNELS);
            end
            if (!grant_found && candidate[scan_idx[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_found && grant_idx == CH_W'(i)) begin
                sel_req.rs1   = ch_rs1[i*XLEN +: XLEN];
                sel_req.rs2   = ch_rs2[i*XLEN +: XLEN];
                sel_req.fn3   = ch_fn3[i*3 +: 3];
                sel_req.load  = ch_load[i];
                sel_req.store = ch_store[i];
                sel_req.id    = ch_id[i*ID_W +: ID_W];
                sel_req.lock  = ch_lock[i];
            end
        end
    end

    assign ls_new_request = grant_found & lsu_ready;
    assign ls_rs1         = sel_req.rs1;
    assign ls_rs2         = sel_req.rs2;
    assign ls_fn3         = sel_req.fn3;
    assign ls_load        = sel_req.load;
    assign ls_store       = sel_req.store;
    assign ls_id          = sel_req.id;
    assign ls_lock        = (state_q == LOCKED) | (sel_req.lock & ls_new_request);
    assign ch_load_data   = lsu_load_data;
    assign tag_underflow  = tag_underflow_q;
    assign fifo_push      = ls_new_request & sel_req.load;

    always_comb begin
        ch_req_ready     = '0;
        ch_load_complete = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_req_ready[i]     = ls_new_request & (grant_idx == CH_W'(i));
            ch_load_complete[i] = lsu_load_complete & ~fifo_empty & (fifo_head == CH_W'(i));
        end
    end

    // The pointer is frozen while locked; the lock ends as soon as the owner drops ch_lock.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        locked_ch_d     = locked_ch_q;
        tag_underflow_d = tag_underflow_q | (lsu_load_complete & fifo_empty);
        case (state_q)
            ARB: begin
                if (ls_new_request) begin
                    rr_ptr_d = (grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
                    if (sel_req.lock) begin
                        locked_ch_d = grant_idx;
                        state_d     = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!ch_lock[locked_ch_q]) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ARB;
            rr_ptr_q        <= '0;
            locked_ch_q     <= '0;
            tag_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            locked_ch_q     <= locked_ch_d;
            tag_underflow_q <= tag_underflow_d;
        end
    end

    rca_lsu_tag_fifo #(
        .DEPTH  (MAX_INFLIGHT_LOADS),
        .DATA_W (CH_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (grant_idx),
        .pop       (lsu_load_complete),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

`ifdef RCA_LSU_ARB_STATS_EN
    logic [31:0] grant_count_q [NUM_CHANNELS];
    logic [31:0] grant_count_d [NUM_CHANNELS];

    always_comb begin
        grant_count_d  = grant_count_q;
        ch_grant_count = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_req_ready[i]) begin
                grant_count_d[i] = grant_count_q[i] + 32'd1;
            end
            ch_grant_count[i*32 +: 32] = grant_count_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                grant_count_q[i] <= '0;
            end
        end else begin
            grant_count_q <= grant_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_rca_lsu_arbiter.sv
// Self-checking bench for rca_lsu_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_rca_lsu_arbiter;

    localparam int N    = 4;
    localparam int D    = 4;
    localparam int XLEN = 32;
    localparam int ID_W = 3;

    logic              clk;
    logic              rst;
    logic [N-1:0]      ch_req_valid, ch_req_ready, ch_load, ch_store, ch_lock, ch_load_complete;
    logic [N*XLEN-1:0] ch_rs1, ch_rs2;
    logic [N*3-1:0]    ch_fn3;
    logic [N*ID_W-1:0] ch_id;
    logic [XLEN-1:0]   ch_load_data, ls_rs1, ls_rs2, lsu_load_data;
    logic              ls_new_request, ls_load, ls_store, ls_lock;
    logic [2:0]        ls_fn3;
    logic [ID_W-1:0]   ls_id;
    logic              lsu_ready, lsu_load_complete, tag_underflow;
`ifdef RCA_LSU_ARB_STATS_EN
    logic [N*32-1:0]   ch_grant_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: the queue holds issuing channels of outstanding loads, oldest first.
    int          mq[$];
    int          m_rr;
    int          m_locked;
    bit          m_uf;
    int unsigned m_cnt[N];
    int          m_g;
    bit          m_req;
    bit          m_lock;
    logic [N-1:0] m_ready;
    logic [N-1:0] m_cpl;

    rca_lsu_arbiter #(
        .NUM_CHANNELS       (N),
        .MAX_INFLIGHT_LOADS (D),
        .XLEN               (XLEN),
        .ID_W               (ID_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ch_req_valid      (ch_req_valid),
        .ch_req_ready      (ch_req_ready),
        .ch_rs1            (ch_rs1),
        .ch_rs2            (ch_rs2),
        .ch_fn3            (ch_fn3),
        .ch_load           (ch_load),
        .ch_store          (ch_store),
        .ch_id             (ch_id),
        .ch_lock           (ch_lock),
        .ch_load_complete  (ch_load_complete),
        .ch_load_data      (ch_load_data),
        .ls_new_request    (ls_new_request),
        .ls_rs1            (ls_rs1),
        .ls_rs2            (ls_rs2),
        .ls_fn3            (ls_fn3),
        .ls_load           (ls_load),
        .ls_store          (ls_store),
        .ls_id             (ls_id),
        .ls_lock           (ls_lock),
        .lsu_ready         (lsu_ready),
        .lsu_load_complete (lsu_load_complete),
        .lsu_load_data     (lsu_load_data),
`ifdef RCA_LSU_ARB_STATS_EN
        .ch_grant_count    (ch_grant_count),
`endif
        .tag_underflow     (tag_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, actual, expected);
        end
    endtask

    // Operands and ids are randomized on every call; directed tests override ids where they matter.
    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] ld, input logic [N-1:0] st,
                                 input logic [N-1:0] lk, input logic rdy, input logic cpl,
                                 input logic [XLEN-1:0] data);
        ch_req_valid      = valid;
        ch_load           = ld;
        ch_store          = st;
        ch_lock           = lk;
        lsu_ready         = rdy;
        lsu_load_complete = cpl;
        lsu_load_data     = data;
        for (int i = 0; i < N; i++) begin
            ch_rs1[i*XLEN +: XLEN] = $urandom;
            ch_rs2[i*XLEN +: XLEN] = $urandom;
            ch_fn3[i*3 +: 3]       = 3'($urandom_range(7));
            ch_id[i*ID_W +: ID_W]  = ID_W'($urandom_range(7));
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit elig(input int c);
        return ch_req_valid[c] && !(ch_load[c] && ch_store[c]) && !(ch_load[c] && mq.size() == D);
    endfunction

    // Compare process: predict outputs from the model, check them, then advance the model
    // by the clock edge that follows (inputs are stable from posedge+1 to the next posedge).
    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            m_rr     = 0;
            m_locked = -1;
            m_uf     = 1'b0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            m_g = -1;
            if (m_locked >= 0) begin
                if (elig(m_locked)) m_g = m_locked;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (m_g < 0 && elig((m_rr + k) % N)) m_g = (m_rr + k) % N;
                end
            end
            m_req   = (m_g >= 0) && lsu_ready;
            m_ready = '0;
            if (m_req) m_ready[m_g] = 1'b1;
            m_lock  = (m_locked >= 0) || (m_req && ch_lock[m_g]);
            m_cpl   = '0;
            if (lsu_load_complete && mq.size() > 0) m_cpl[mq[0]] = 1'b1;

            checkOutput("ls_new_request", ls_new_request, m_req);
            checkOutput("ch_req_ready", ch_req_ready, m_ready);
            checkOutput("ls_lock", ls_lock, m_lock);
            checkOutput("ch_load_complete", ch_load_complete, m_cpl);
            checkOutput("tag_underflow", tag_underflow, m_uf);
            if (m_req) begin
                checkOutput("ls_rs1", ls_rs1, ch_rs1[m_g*XLEN +: XLEN]);
                checkOutput("ls_rs2", ls_rs2, ch_rs2[m_g*XLEN +: XLEN]);
                checkOutput("ls_fn3", ls_fn3, ch_fn3[m_g*3 +: 3]);
                checkOutput("ls_id", ls_id, ch_id[m_g*ID_W +: ID_W]);
                checkOutput("ls_load", ls_load, ch_load[m_g]);
                checkOutput("ls_store", ls_store, ch_store[m_g]);
            end
            if (lsu_load_complete) checkOutput("ch_load_data", ch_load_data, lsu_load_data);
`ifdef RCA_LSU_ARB_STATS_EN
            for (int i = 0; i < N; i++) checkOutput("ch_grant_count", ch_grant_count[i*32 +: 32], m_cnt[i]);
`endif

            if (lsu_load_complete) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_uf = 1'b1;
            end
            if (m_req) begin
                if (ch_load[m_g]) mq.push_back(m_g);
                m_cnt[m_g]++;
            end
            if (m_locked >= 0) begin
                if (!ch_lock[m_locked]) m_locked = -1;
            end else if (m_req) begin
                m_rr = (m_g + 1) % N;
                if (ch_lock[m_g]) m_locked = m_g;
            end
        end
    end

    initial begin
        logic [N-1:0] exp_v;
        logic [N-1:0] v, ld, st, lk;
        logic [XLEN-1:0] cpl_data [3];

        rst = 1'b1;
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, '0);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_ready", ch_req_ready, '0);
        checkOutput("reset_new_request", ls_new_request, 0);
        checkOutput("reset_ls_lock", ls_lock, 0);
        checkOutput("reset_underflow", tag_underflow, 0);
        checkOutput("reset_complete", ch_load_complete, '0);
        nextCycle();
        rst = 1'b1;

        // Round-robin over four store requesters.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, '0);
            @(negedge clk);
            exp_v = '0;
            exp_v[k % 4] = 1'b1;
            checkOutput("rr_ready", ch_req_ready, exp_v);
            nextCycle();
        end

        // Backpressure: nothing accepted while the LSU is not ready.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0010, 4'b0000, 4'b0010, 4'b0000, (k == 3), 1'b0, '0);
            @(negedge clk);
            checkOutput("bp_new_request", ls_new_request, (k == 3));
            checkOutput("bp_ready", ch_req_ready, (k == 3) ? 4'b0010 : 4'b0000);
            nextCycle();
        end
        applyStimulus(4'b0101, 4'b0000, 4'b0101, 4'b0000, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("bp_rr_after", ch_req_ready, 4'b0100);
        nextCycle();

        // Lock: ch2 locked load, then others are shut out until ch2 drops lock.
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("lock_grant", ch_req_ready, 4'b0100);
        checkOutput("lock_ls_lock", ls_lock, 1);
        nextCycle();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1001 | ((k % 2 == 1) ? 4'b0100 : 4'b0000), 4'b0000, 4'b1101, 4'b0100, 1'b1, 1'b0, '0);
            @(negedge clk);
            checkOutput("locked_ready", ch_req_ready, (k % 2 == 1) ? 4'b0100 : 4'b0000);
            checkOutput("locked_ls_lock", ls_lock, 1);
            nextCycle();
        end
        applyStimulus(4'b1001, 4'b0000, 4'b1001, 4'b0000, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("unlock_cycle_ready", ch_req_ready, 4'b0000);
        checkOutput("unlock_cycle_ls_lock", ls_lock, 1);
        nextCycle();
        applyStimulus(4'b1001, 4'b0000, 4'b1001, 4'b0000, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("after_unlock_grant", ch_req_ready, 4'b1000);
        checkOutput("after_unlock_ls_lock", ls_lock, 0);
        nextCycle();
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b1, 32'h55);
        @(negedge clk);
        checkOutput("lock_load_route", ch_load_complete, 4'b0100);
        nextCycle();

        // Routing: loads ch3 (id 5), ch0 (id 1), ch3 (id 6), then three in-order completions.
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
        ch_id[3*ID_W +: ID_W] = 3'd5;
        @(negedge clk);
        checkOutput("route_issue0", ch_req_ready, 4'b1000);
        checkOutput("route_id0", ls_id, 5);
        nextCycle();
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
        ch_id[0 +: ID_W] = 3'd1;
        @(negedge clk);
        checkOutput("route_issue1", ch_req_ready, 4'b0001);
        checkOutput("route_id1", ls_id, 1);
        nextCycle();
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
        ch_id[3*ID_W +: ID_W] = 3'd6;
        @(negedge clk);
        checkOutput("route_issue2", ch_req_ready, 4'b1000);
        checkOutput("route_id2", ls_id, 6);
        nextCycle();
        cpl_data[0] = 32'hA;
        cpl_data[1] = 32'hB;
        cpl_data[2] = 32'hC;
        for (int k = 0; k < 3; k++) begin
            applyStimulus('0, '0, '0, '0, 1'b0, 1'b1, cpl_data[k]);
            @(negedge clk);
            checkOutput("route_complete", ch_load_complete, (k == 1) ? 4'b0001 : 4'b1000);
            checkOutput("route_data", ch_load_data, cpl_data[k]);
            nextCycle();
        end

        // Full FIFO: stores bypass, loads wait until a completion has actually popped.
        for (int k = 0; k < 4; k++) begin
            exp_v = '0;
            exp_v[k] = 1'b1;
            applyStimulus(exp_v, exp_v, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
            @(negedge clk);
            checkOutput("fill_ready", ch_req_ready, exp_v);
            nextCycle();
        end
        applyStimulus(4'b0110, 4'b0010, 4'b0100, 4'b0000, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("full_store_bypass", ch_req_ready, 4'b0100);
        nextCycle();
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h1);
        @(negedge clk);
        checkOutput("full_pop_no_unblock", ch_req_ready, 4'b0000);
        checkOutput("full_pop_route", ch_load_complete, 4'b0001);
        nextCycle();
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("full_unblocked", ch_req_ready, 4'b0010);
        nextCycle();
        for (int k = 0; k < 4; k++) begin
            applyStimulus('0, '0, '0, '0, 1'b0, 1'b1, 32'(k));
            @(negedge clk);
            checkOutput("drain_route", ch_load_complete,
                        (k == 1) ? 4'b0100 : ((k == 2) ? 4'b1000 : 4'b0010));
            nextCycle();
        end

        // Underflow: completion with an empty FIFO routes nowhere and sets the sticky flag.
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b1, 32'hDEAD);
        @(negedge clk);
        checkOutput("uf_no_route", ch_load_complete, 4'b0000);
        checkOutput("uf_not_yet", tag_underflow, 0);
        nextCycle();
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checkOutput("uf_sticky", tag_underflow, 1);
        nextCycle();

        // Asynchronous reset while ch1 holds a lock.
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("pre_reset_grant", ch_req_ready, 4'b0010);
        nextCycle();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("pre_reset_lock", ls_lock, 1);
        nextCycle();
        #2;
        rst = 1'b0;
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        checkOutput("async_reset_ls_lock", ls_lock, 0);
        checkOutput("async_reset_underflow", tag_underflow, 0);
        checkOutput("async_reset_ready", ch_req_ready, '0);
        checkOutput("async_reset_new_request", ls_new_request, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        nextCycle();
        applyStimulus(4'b0011, 4'b0000, 4'b0011, 4'b0010, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("post_reset_arb", ch_req_ready, 4'b0001);
        checkOutput("post_reset_ls_lock", ls_lock, 0);
        nextCycle();

        // Randomized traffic; completions are only issued while loads are outstanding.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                v[i]  = 1'($urandom_range(1));
                ld[i] = 1'($urandom_range(1));
                st[i] = 1'($urandom_range(1));
                lk[i] = ($urandom_range(7) == 0);
            end
            if (m_locked >= 0) lk[m_locked] = ($urandom_range(3) != 0);
            applyStimulus(v, ld, st, lk, ($urandom_range(3) != 0),
                          (mq.size() > 0) && ($urandom_range(9) < 4), $urandom);
            nextCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
